// File: rtl/meriac_play_tune_pkg.sv
// Shared constants for the tune player: note half-periods, ROM entry layout
// and the looping melody itself.
package meriac_play_tune_pkg;

    localparam int TUNE_LEN = 15;
    localparam int HP_W     = 6;

    localparam logic [HP_W-1:0] HP_C = 6'd60;
    localparam logic [HP_W-1:0] HP_D = 6'd53;
    localparam logic [HP_W-1:0] HP_E = 6'd48;
    localparam logic [HP_W-1:0] HP_F = 6'd45;
    localparam logic [HP_W-1:0] HP_G = 6'd40;
    localparam logic [HP_W-1:0] HP_A = 6'd36;

    typedef struct packed {
        logic            rest;
        logic [1:0]      dur;
        logic [HP_W-1:0] note;
    } tune_entry_t;

    // The rest entry carries a valid half-period so the tone counter never sees 0.
    localparam tune_entry_t TUNE_ROM [TUNE_LEN] = '{
        '{1'b0, 2'd1, HP_C}, '{1'b0, 2'd1, HP_C},
        '{1'b0, 2'd1, HP_G}, '{1'b0, 2'd1, HP_G},
        '{1'b0, 2'd1, HP_A}, '{1'b0, 2'd1, HP_A},
        '{1'b0, 2'd2, HP_G},
        '{1'b0, 2'd1, HP_F}, '{1'b0, 2'd1, HP_F},
        '{1'b0, 2'd1, HP_E}, '{1'b0, 2'd1, HP_E},
        '{1'b0, 2'd1, HP_D}, '{1'b0, 2'd1, HP_D},
        '{1'b0, 2'd2, HP_C},
        '{1'b1, 2'd2, HP_C}
    };

endpackage

// File: rtl/meriac_play_tune_tone_gen.sv
// Square-wave generator: toggles tone every half_period clocks while enabled;
// clear restarts the phase with tone low.
import meriac_play_tune_pkg::*;

module meriac_play_tune_tone_gen (
    input  logic            clk,
    input  logic            clear,
    input  logic [HP_W-1:0] half_period,
    input  logic            enable,
    output logic            tone
);

    logic [HP_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (enable) begin
            if (cnt == half_period - HP_W'(1)) begin
                cnt  <= '0;
                tone <= ~tone;
            end else begin
                cnt <= cnt + HP_W'(1);
            end
        end
    end

endmodule

// File: rtl/meriac_play_tune.sv
// Tile top: beat prescaler, beat counter and ROM sequencer driving a
// differential speaker pair on io_out[1:0].
import meriac_play_tune_pkg::*;

module meriac_play_tune #(
    parameter int MAX_COUNT = 10000
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int              PW   = $clog2(MAX_COUNT);
    localparam logic [PW-1:0]   LAST = PW'(MAX_COUNT - 1);

    logic          clk;
    logic          rst;
    logic          unused_pins;
    logic [PW-1:0] presc;
    logic [2:0]    beat;
    logic [3:0]    idx;
    tune_entry_t   cur;
    logic          beat_end;
    logic          advance;
    logic          tone;
    logic [1:0]    speaker;

    assign clk         = io_in[0];
    assign rst         = io_in[1];
    assign unused_pins = ^io_in[7:2];

    assign cur      = TUNE_ROM[idx];
    assign beat_end = (presc == LAST);
    assign advance  = beat_end && (beat == ({1'b0, cur.dur} - 3'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            beat  <= '0;
            idx   <= '0;
        end else begin
            presc <= beat_end ? '0 : presc + PW'(1);
            if (advance) begin
                beat <= '0;
                idx  <= (idx == 4'(TUNE_LEN - 1)) ? 4'd0 : idx + 4'd1;
            end else if (beat_end) begin
                beat <= beat + 3'd1;
            end
        end
    end

    // Every note, including a repeat of the same pitch, restarts with tone low.
    meriac_play_tune_tone_gen u_tone (
        .clk         (clk),
        .clear       (rst | advance),
        .half_period (cur.note),
        .enable      (~cur.rest),
        .tone        (tone)
    );

    assign speaker = (rst || cur.rest) ? 2'b00 : {~tone, tone};
    assign io_out  = {6'b0, speaker};

endmodule

// File: tb/tb_meriac_play_tune.sv
// Bench for meriac_play_tune (MAX_COUNT=100): reset, full loop, mid-note
// reset and randomised unused pins against a time-based melody model.
module tb_meriac_play_tune;

    localparam int MC   = 100;
    localparam int LOOP = 18 * MC;
    localparam int RUN  = 2000;

    // Melody as beats and half-periods; 0 marks the rest.
    localparam int DUR [15] = '{1,1,1,1,1,1,2,1,1,1,1,1,1,2,2};
    localparam int HP  [15] = '{60,60,40,40,36,36,40,45,45,48,48,53,53,60,0};

    // Hand-picked points from the melody timeline (speaker: 2=10, 1=01, 0=00).
    localparam int NSPOT = 25;
    localparam int SPOT_K [NSPOT] = '{0,59,60,99,100,200,239,240,279,280,600,640,680,760,799,
                                      800,845,1400,1460,1599,1600,1799,1800,1859,1860};
    localparam int SPOT_V [NSPOT] = '{2,2,1,1,2,2,2,1,1,2,2,1,2,2,2,
                                      2,1,2,1,1,0,0,2,2,1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] junk = 6'd0;
    bit         junk_en = 1'b0;
    logic [7:0] io_in;
    logic [7:0] io_out;
    logic [1:0] trace0 [RUN];

    int n_tests = 0;
    int n_fail  = 0;

    assign io_in = {junk, rst, clk};

    meriac_play_tune #(.MAX_COUNT(MC)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (junk_en) junk = 6'($urandom);
    end

    // Expected speaker k clocks after reset release, derived from note lengths.
    function automatic logic [1:0] model_spk(input int k);
        int t;
        int e;
        t = k % LOOP;
        e = 0;
        while (t >= DUR[e] * MC) begin
            t -= DUR[e] * MC;
            e++;
        end
        if (HP[e] == 0) return 2'b00;
        return ((t / HP[e]) % 2 == 1) ? 2'b01 : 2'b10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench at the k=0 sample point.
    task automatic hold_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (io_out !== 8'h00) begin
                n_fail++;
                $display("FAIL reset cyc=%0d io_out=%h expected=00", i, io_out);
            end
            tick();
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_full_loop();
        logic [1:0] exp;
        for (int k = 0; k < RUN; k++) begin
            if (k != 0) tick();
            exp = model_spk(k);
            trace0[k] = io_out[1:0];
            n_tests++;
            if (io_out !== {6'b0, exp}) begin
                n_fail++;
                $display("FAIL loop k=%0d io_out=%b expected=%b", k, io_out, {6'b0, exp});
            end
            for (int s = 0; s < NSPOT; s++) begin
                if (SPOT_K[s] == k) begin
                    n_tests++;
                    if (io_out[1:0] !== 2'(SPOT_V[s])) begin
                        n_fail++;
                        $display("FAIL spot k=%0d speaker=%b expected=%b", k, io_out[1:0], 2'(SPOT_V[s]));
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [1:0] exp;
        hold_reset(2);
        for (int k = 0; k <= 450; k++) begin
            if (k != 0) tick();
            exp = model_spk(k);
            n_tests++;
            if (io_out[1:0] !== exp) begin
                n_fail++;
                $display("FAIL pre_rst k=%0d speaker=%b expected=%b", k, io_out[1:0], exp);
            end
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (io_out !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_rst_comb io_out=%h expected=00", io_out);
        end
        tick();
        n_tests++;
        if (io_out !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_rst_edge io_out=%h expected=00", io_out);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 300; k++) begin
            if (k != 0) tick();
            exp = model_spk(k);
            n_tests++;
            if (io_out !== {6'b0, exp}) begin
                n_fail++;
                $display("FAIL replay k=%0d io_out=%b expected=%b", k, io_out, {6'b0, exp});
            end
            for (int s = 0; s < NSPOT; s++) begin
                if (SPOT_K[s] == k) begin
                    n_tests++;
                    if (io_out[1:0] !== 2'(SPOT_V[s])) begin
                        n_fail++;
                        $display("FAIL replay_spot k=%0d speaker=%b expected=%b", k, io_out[1:0], 2'(SPOT_V[s]));
                    end
                end
            end
        end
    endtask

    task automatic test_unused_pins();
        junk_en = 1'b1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (io_out !== 8'h00) begin
                n_fail++;
                $display("FAIL junk_reset cyc=%0d io_out=%h expected=00", i, io_out);
            end
            tick();
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < RUN; k++) begin
            if (k != 0) tick();
            n_tests++;
            if (io_out[7:2] !== 6'd0) begin
                n_fail++;
                $display("FAIL junk_upper k=%0d io_out=%b expected=000000xx", k, io_out);
            end
            n_tests++;
            if (io_out[1:0] !== trace0[k]) begin
                n_fail++;
                $display("FAIL junk_trace k=%0d speaker=%b expected=%b", k, io_out[1:0], trace0[k]);
            end
            n_tests++;
            if (io_out[1:0] !== model_spk(k)) begin
                n_fail++;
                $display("FAIL junk_model k=%0d speaker=%b expected=%b", k, io_out[1:0], model_spk(k));
            end
        end
        junk_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_loop();
        test_mid_reset();
        test_unused_pins();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
